alu_cmd_issuer: RTL and testbench
=================================

# alu_cmd_issuer

Command-side front end for the registered 8-bit ALU.
- Accepts operation commands over a valid/ready handshake and drives them onto the ALU operand and opcode inputs.
- Waits out the ALU's registered latency, captures the 16-bit result, and returns it with the command tag over a valid/ready response handshake.
- Sits between the instruction/control logic and the ALU. It is the only block that drives the ALU inputs.

## Interface
Parameters:
- ALU_LAT, default 1: clock edges between operands being driven and alu_result being stable (range 1–7).
- TAG_W, default 4: width of the command/response tag.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  issuer can accept a command.
- cmd_opcode  in  3  ALU opcode: 000 add, 001 sub, 010 mul, 011 shl a, 100 shr a, 101 and, 110 or, 111 xor.
- cmd_a, cmd_b  in  8 each  operands.
- cmd_tag  in  TAG_W  opaque tag, returned unchanged.
- alu_a, alu_b  out  8 each  ALU operands.
- alu_opcode  out  3  ALU opcode.
- alu_result  in  16  ALU result.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_result  out  16  captured ALU result.
- rsp_cout  out  1  carry-out of the add.
- rsp_tag  out  TAG_W  tag of the completed command.
- op_count  out  16  number of completed responses; wraps.

## Operation
- The FSM has four states: IDLE, DRIVE, WAIT, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, latch opcode, a, b and tag, then go to DRIVE.
- DRIVE (one cycle):
  - alu_a, alu_b and alu_opcode present the latched values. They are registered outputs, updated on the accept edge.
  - Load the wait counter with ALU_LAT-1, then go to WAIT.
- WAIT:
  - Decrement the counter each cycle. When it is 0, capture alu_result into rsp_result and set rsp_valid, then go to RESP.
  - With ALU_LAT=1, WAIT lasts one cycle.
- RESP:
  - rsp_valid=1; rsp_result, rsp_cout and rsp_tag are held stable.
  - On rsp_valid&rsp_ready: clear rsp_valid, increment op_count (mod 2^16), go to IDLE.
- rsp_cout is computed locally from the latched operands, not taken from the ALU:
  - bit 8 of the 9-bit sum {1'b0,a}+{1'b0,b} when the opcode is 000;
  - 0 for every other opcode.
- rsp_result is alu_result taken verbatim. It is not truncated or sign-extended.
- alu_a, alu_b and alu_opcode keep their last driven value outside DRIVE/WAIT. They change only on a command accept.
- cmd_ready=0 in DRIVE, WAIT and RESP. There is no command buffering and only one operation is in flight.
- cmd_valid with cmd_ready=0 is ignored. The source must hold its command.
- Reset mid-operation: the in-flight command is dropped, no response is issued, and the FSM returns to IDLE.

## Timing
- Reset values:
  - cmd_ready=1 (combinational from IDLE).
  - rsp_valid=0.
  - rsp_result=16'h0000, rsp_cout=0, rsp_tag=0.
  - alu_a=alu_b=8'h00, alu_opcode=3'b000.
  - op_count=16'h0000.
- Latency: accept at edge E. alu_* are valid after E. rsp_valid rises after edge E+1+ALU_LAT, which is 3 edges for ALU_LAT=1.
- Throughput: with rsp_ready held high, one command per ALU_LAT+3 cycles.
- The response handshake completes in the same cycle rsp_ready is seen. The next command can be accepted in the cycle after that.
- op_count updates on the response-handshake edge. 16'hFFFF+1 wraps to 16'h0000.

## Test plan
- Add with carry: a=8'hC8, b=8'h64, op 000, tag 3, using a bench ALU model with registered latency of 1 -> after 3 edges rsp_valid=1, rsp_result=16'h012C, rsp_cout=1, rsp_tag=3, op_count=1.
- Multiply: a=8'hFF, b=8'hFF, op 010 -> rsp_result=16'hFE01, rsp_cout=0; alu_opcode=010 from DRIVE onward.
- Back-pressure: rsp_ready low for 10 cycles after rsp_valid -> outputs stable, cmd_ready=0, and a second cmd_valid is not accepted until the cycle after the response handshake.
- ALU_LAT=3 with op 111 on 8'hA5^8'h0F -> rsp_valid 5 edges after accept, rsp_result=16'h00AA.
- Reset asserted during WAIT -> all outputs at reset values immediately, no rsp_valid after release, and the next command completes normally.
- op_count preloaded to 16'hFFFF via 65535 back-to-back ops (or force), then one more -> op_count=16'h0000.

Source files
------------

// File: rtl/alu_cmd_issuer.sv
// Command-side front end for the registered 8-bit ALU: accepts one command,
// drives the ALU, waits out its latency and returns the result with the tag.
module alu_cmd_issuer #(
    parameter int ALU_LAT = 1,
    parameter int TAG_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_opcode,
    input  logic [7:0]       cmd_a,
    input  logic [7:0]       cmd_b,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic [7:0]       alu_a,
    output logic [7:0]       alu_b,
    output logic [2:0]       alu_opcode,
    input  logic [15:0]      alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [15:0]      rsp_result,
    output logic             rsp_cout,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [15:0]      op_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [2:0] LAT_M1 = 3'(ALU_LAT - 1);

    state_t           state_r;
    state_t           state_next_s;
    logic [2:0]       wait_cnt_r;
    logic [TAG_W-1:0] tag_r;
    logic [7:0]       alu_a_r;
    logic [7:0]       alu_b_r;
    logic [2:0]       alu_opcode_r;
    logic             rsp_valid_r;
    logic [15:0]      rsp_result_r;
    logic             rsp_cout_r;
    logic [TAG_W-1:0] rsp_tag_r;
    logic [15:0]      op_count_r;
    logic             accept_s;
    logic             rsp_fire_s;
    logic             wait_done_s;

    // Carry is derived from the operands so it does not depend on the ALU's result encoding.
    function automatic logic add_carry(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum9;
        sum9 = {1'b0, a} + {1'b0, b};
        return (op == 3'b000) ? sum9[8] : 1'b0;
    endfunction

    assign accept_s    = cmd_valid & cmd_ready;
    assign rsp_fire_s  = rsp_valid_r & rsp_ready;
    assign wait_done_s = (state_r == S_WAIT) && (wait_cnt_r == 3'd0);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    state_next_s = S_DRIVE;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_DRIVE: state_next_s = S_WAIT;
            S_WAIT: begin
                if (wait_cnt_r == 3'd0) begin
                    state_next_s = S_RESP;
                end else begin
                    state_next_s = S_WAIT;
                end
            end
            S_RESP: begin
                if (rsp_fire_s) begin
                    state_next_s = S_IDLE;
                end else begin
                    state_next_s = S_RESP;
                end
            end
            default: state_next_s = S_IDLE;
        endcase
    end

    // Output logic: only IDLE accepts commands.
    always_comb begin
        if (state_r == S_IDLE) begin
            cmd_ready = 1'b1;
        end else begin
            cmd_ready = 1'b0;
        end
    end

    // Command latch, latency counter, response capture and completion count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a_r      <= 8'h00;
            alu_b_r      <= 8'h00;
            alu_opcode_r <= 3'b000;
            tag_r        <= '0;
            wait_cnt_r   <= 3'd0;
            rsp_valid_r  <= 1'b0;
            rsp_result_r <= 16'h0000;
            rsp_cout_r   <= 1'b0;
            rsp_tag_r    <= '0;
            op_count_r   <= 16'h0000;
        end else begin
            if (accept_s) begin
                alu_a_r      <= cmd_a;
                alu_b_r      <= cmd_b;
                alu_opcode_r <= cmd_opcode;
                tag_r        <= cmd_tag;
            end
            if (state_r == S_DRIVE) begin
                wait_cnt_r <= LAT_M1;
            end else if ((state_r == S_WAIT) && (wait_cnt_r != 3'd0)) begin
                wait_cnt_r <= wait_cnt_r - 3'd1;
            end
            if (wait_done_s) begin
                rsp_valid_r  <= 1'b1;
                rsp_result_r <= alu_result;
                rsp_cout_r   <= add_carry(alu_opcode_r, alu_a_r, alu_b_r);
                rsp_tag_r    <= tag_r;
            end else if (rsp_fire_s) begin
                rsp_valid_r <= 1'b0;
                op_count_r  <= op_count_r + 16'd1;
            end
        end
    end

    assign alu_a      = alu_a_r;
    assign alu_b      = alu_b_r;
    assign alu_opcode = alu_opcode_r;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_result = rsp_result_r;
    assign rsp_cout   = rsp_cout_r;
    assign rsp_tag    = rsp_tag_r;
    assign op_count   = op_count_r;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Bench for alu_cmd_issuer: instance 0 (ALU_LAT=1) is checked every cycle against a
// timestamp-based model; instance 1 (ALU_LAT=3) is checked with directed expectations.
module tb_alu_cmd_issuer;

    localparam int L0 = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid_v  [2];
    logic        cmd_ready_v  [2];
    logic [2:0]  cmd_opcode_v [2];
    logic [7:0]  cmd_a_v      [2];
    logic [7:0]  cmd_b_v      [2];
    logic [3:0]  cmd_tag_v    [2];
    logic [7:0]  alu_a_v      [2];
    logic [7:0]  alu_b_v      [2];
    logic [2:0]  alu_opcode_v [2];
    logic [15:0] alu_result_v [2];
    logic        rsp_valid_v  [2];
    logic        rsp_ready_v  [2];
    logic [15:0] rsp_result_v [2];
    logic        rsp_cout_v   [2];
    logic [3:0]  rsp_tag_v    [2];
    logic [15:0] op_count_v   [2];

    int checks = 0;
    int failures = 0;
    logic preload = 1'b0;

    always #5 clk = ~clk;

    alu_cmd_issuer #(.ALU_LAT(1), .TAG_W(4)) u0 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid_v[0]), .cmd_ready(cmd_ready_v[0]), .cmd_opcode(cmd_opcode_v[0]),
        .cmd_a(cmd_a_v[0]), .cmd_b(cmd_b_v[0]), .cmd_tag(cmd_tag_v[0]),
        .alu_a(alu_a_v[0]), .alu_b(alu_b_v[0]), .alu_opcode(alu_opcode_v[0]),
        .alu_result(alu_result_v[0]), .rsp_valid(rsp_valid_v[0]), .rsp_ready(rsp_ready_v[0]),
        .rsp_result(rsp_result_v[0]), .rsp_cout(rsp_cout_v[0]), .rsp_tag(rsp_tag_v[0]),
        .op_count(op_count_v[0])
    );

    alu_cmd_issuer #(.ALU_LAT(3), .TAG_W(4)) u1 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid_v[1]), .cmd_ready(cmd_ready_v[1]), .cmd_opcode(cmd_opcode_v[1]),
        .cmd_a(cmd_a_v[1]), .cmd_b(cmd_b_v[1]), .cmd_tag(cmd_tag_v[1]),
        .alu_a(alu_a_v[1]), .alu_b(alu_b_v[1]), .alu_opcode(alu_opcode_v[1]),
        .alu_result(alu_result_v[1]), .rsp_valid(rsp_valid_v[1]), .rsp_ready(rsp_ready_v[1]),
        .rsp_result(rsp_result_v[1]), .rsp_cout(rsp_cout_v[1]), .rsp_tag(rsp_tag_v[1]),
        .op_count(op_count_v[1])
    );

    function automatic logic [15:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'b000:  return {8'h00, a} + {8'h00, b};
            3'b001:  return {8'h00, a} - {8'h00, b};
            3'b010:  return {8'h00, a} * {8'h00, b};
            3'b011:  return {8'h00, a} << 1;
            3'b100:  return {8'h00, a} >> 1;
            3'b101:  return {8'h00, a & b};
            3'b110:  return {8'h00, a | b};
            3'b111:  return {8'h00, a ^ b};
            default: return 16'h0000;
        endcase
    endfunction

    // Bench ALUs with registered latency 1 and 3.
    logic [15:0] pipe0;
    logic [15:0] pipe1 [3];
    always_ff @(posedge clk) begin
        pipe0    <= alu_fn(alu_opcode_v[0], alu_a_v[0], alu_b_v[0]);
        pipe1[0] <= alu_fn(alu_opcode_v[1], alu_a_v[1], alu_b_v[1]);
        pipe1[1] <= pipe1[0];
        pipe1[2] <= pipe1[1];
    end
    assign alu_result_v[0] = pipe0;
    assign alu_result_v[1] = pipe1[2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Model of instance 0: busy from accept until response handshake, response due
    // 1+L0 edges after the accept edge.
    logic        m_busy, m_valid, m_cout;
    int          m_edges;
    logic [7:0]  m_a, m_b;
    logic [2:0]  m_op;
    logic [3:0]  m_tag, m_rtag;
    logic [15:0] m_res, m_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_valid <= 1'b0; m_cout <= 1'b0; m_edges <= 0;
            m_a <= 8'h00; m_b <= 8'h00; m_op <= 3'b000; m_tag <= 4'h0; m_rtag <= 4'h0;
            m_res <= 16'h0000; m_cnt <= 16'h0000;
        end else begin
            if (preload) m_cnt <= 16'hFFFF;
            if (!m_busy) begin
                if (cmd_valid_v[0]) begin
                    m_busy <= 1'b1; m_edges <= 0;
                    m_a <= cmd_a_v[0]; m_b <= cmd_b_v[0]; m_op <= cmd_opcode_v[0]; m_tag <= cmd_tag_v[0];
                end
            end else if (!m_valid) begin
                m_edges <= m_edges + 1;
                if (m_edges + 1 == 1 + L0) begin
                    m_valid <= 1'b1;
                    m_res   <= alu_fn(m_op, m_a, m_b);
                    m_cout  <= (m_op == 3'b000) && ((int'(m_a) + int'(m_b)) > 255);
                    m_rtag  <= m_tag;
                end
            end else if (rsp_ready_v[0]) begin
                m_valid <= 1'b0; m_busy <= 1'b0; m_cnt <= m_cnt + 16'd1;
            end
        end
    end

    // Per-cycle comparison of instance 0 against the model.
    always @(negedge clk) begin
        chk("cmd_ready", 32'(cmd_ready_v[0]), 32'(!m_busy));
        chk("rsp_valid", 32'(rsp_valid_v[0]), 32'(m_valid));
        chk("alu_a", 32'(alu_a_v[0]), 32'(m_a));
        chk("alu_b", 32'(alu_b_v[0]), 32'(m_b));
        chk("alu_opcode", 32'(alu_opcode_v[0]), 32'(m_op));
        chk("rsp_result", 32'(rsp_result_v[0]), 32'(m_res));
        chk("rsp_cout", 32'(rsp_cout_v[0]), 32'(m_cout));
        chk("rsp_tag", 32'(rsp_tag_v[0]), 32'(m_rtag));
        chk("op_count", 32'(op_count_v[0]), 32'(m_cnt));
    end

    task automatic accept_cmd(input int d, input logic [2:0] op, input logic [7:0] a,
                              input logic [7:0] b, input logic [3:0] tag);
        bit got;
        got = 1'b0;
        @(posedge clk); #1;
        cmd_valid_v[d] = 1'b1; cmd_opcode_v[d] = op; cmd_a_v[d] = a; cmd_b_v[d] = b; cmd_tag_v[d] = tag;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_ready_v[d]) begin
                got = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        cmd_valid_v[d] = 1'b0;
        chk("accept_timeout", 32'(got), 32'd1);
    endtask

    // Counts edges from the accept edge (inclusive) to rsp_valid.
    task automatic wait_rsp(input int d, output int n);
        bit got;
        got = 1'b0;
        n = 1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (rsp_valid_v[d]) begin
                got = 1'b1;
                break;
            end
        end
        chk("rsp_timeout", 32'(got), 32'd1);
    endtask

    task automatic respond(input int d);
        @(posedge clk); #1;
        rsp_ready_v[d] = 1'b1;
        @(posedge clk); #1;
        rsp_ready_v[d] = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int n;
        for (int d = 0; d < 2; d++) begin
            cmd_valid_v[d] = 1'b0; cmd_opcode_v[d] = 3'b000; cmd_a_v[d] = 8'h00;
            cmd_b_v[d] = 8'h00; cmd_tag_v[d] = 4'h0; rsp_ready_v[d] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("reset_cmd_ready", 32'(cmd_ready_v[0]), 32'd1);
        chk("reset_rsp_valid", 32'(rsp_valid_v[0]), 32'd0);
        chk("reset_op_count", 32'(op_count_v[1]), 32'h0000);
        rst_n = 1'b1;

        // Add with carry.
        accept_cmd(0, 3'b000, 8'hC8, 8'h64, 4'd3);
        wait_rsp(0, n);
        chk("add_latency", 32'(n), 32'd3);
        chk("add_result", 32'(rsp_result_v[0]), 32'h012C);
        chk("add_cout", 32'(rsp_cout_v[0]), 32'd1);
        chk("add_tag", 32'(rsp_tag_v[0]), 32'd3);
        respond(0);
        chk("add_op_count", 32'(op_count_v[0]), 32'd1);

        // Multiply.
        accept_cmd(0, 3'b010, 8'hFF, 8'hFF, 4'd7);
        chk("mul_alu_opcode", 32'(alu_opcode_v[0]), 32'b010);
        wait_rsp(0, n);
        chk("mul_result", 32'(rsp_result_v[0]), 32'hFE01);
        chk("mul_cout", 32'(rsp_cout_v[0]), 32'd0);
        respond(0);

        // Subtract: 16-bit borrow result is passed through untouched.
        accept_cmd(0, 3'b001, 8'h05, 8'h07, 4'd1);
        wait_rsp(0, n);
        chk("sub_result", 32'(rsp_result_v[0]), 32'hFFFE);
        respond(0);

        // Back-pressure with a second command waiting.
        accept_cmd(0, 3'b000, 8'h80, 8'h80, 4'd9);
        wait_rsp(0, n);
        @(posedge clk); #1;
        cmd_valid_v[0] = 1'b1; cmd_opcode_v[0] = 3'b101; cmd_a_v[0] = 8'h3C; cmd_b_v[0] = 8'h0F; cmd_tag_v[0] = 4'd2;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_rsp_valid", 32'(rsp_valid_v[0]), 32'd1);
            chk("bp_cmd_ready", 32'(cmd_ready_v[0]), 32'd0);
            chk("bp_result", 32'(rsp_result_v[0]), 32'h0100);
            chk("bp_tag", 32'(rsp_tag_v[0]), 32'd9);
        end
        @(posedge clk); #1;
        rsp_ready_v[0] = 1'b1;
        @(posedge clk); #1;
        rsp_ready_v[0] = 1'b0;
        @(negedge clk);
        chk("bp_after_hs_ready", 32'(cmd_ready_v[0]), 32'd1);
        chk("bp_after_hs_alu_a", 32'(alu_a_v[0]), 32'h80);
        @(posedge clk); #1;
        cmd_valid_v[0] = 1'b0;
        @(negedge clk);
        chk("bp_second_accepted", 32'(alu_a_v[0]), 32'h3C);
        wait_rsp(0, n);
        chk("bp_second_latency", 32'(n), 32'd3);
        chk("bp_second_result", 32'(rsp_result_v[0]), 32'h000C);
        respond(0);

        // Reset during WAIT.
        accept_cmd(0, 3'b110, 8'h12, 8'h34, 4'd4);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready_v[0]), 32'd1);
        chk("rst_alu_a", 32'(alu_a_v[0]), 32'h00);
        chk("rst_op_count", 32'(op_count_v[0]), 32'h0000);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rst_no_rsp", 32'(rsp_valid_v[0]), 32'd0);
        end
        accept_cmd(0, 3'b000, 8'h01, 8'h02, 4'd6);
        wait_rsp(0, n);
        chk("post_rst_result", 32'(rsp_result_v[0]), 32'h0003);
        respond(0);
        chk("post_rst_count", 32'(op_count_v[0]), 32'd1);

        // op_count wrap.
        @(negedge clk); #1;
        force u0.op_count_r = 16'hFFFF;
        preload = 1'b1;
        @(posedge clk); #1;
        preload = 1'b0;
        release u0.op_count_r;
        @(negedge clk);
        chk("preload_count", 32'(op_count_v[0]), 32'hFFFF);
        accept_cmd(0, 3'b100, 8'h81, 8'h00, 4'd8);
        wait_rsp(0, n);
        chk("shr_result", 32'(rsp_result_v[0]), 32'h0040);
        respond(0);
        chk("wrap_count", 32'(op_count_v[0]), 32'h0000);

        // ALU_LAT=3 instance.
        accept_cmd(1, 3'b111, 8'hA5, 8'h0F, 4'd5);
        chk("lat3_alu_opcode", 32'(alu_opcode_v[1]), 32'b111);
        wait_rsp(1, n);
        chk("lat3_latency", 32'(n), 32'd5);
        chk("lat3_result", 32'(rsp_result_v[1]), 32'h00AA);
        chk("lat3_tag", 32'(rsp_tag_v[1]), 32'd5);
        chk("lat3_cout", 32'(rsp_cout_v[1]), 32'd0);
        respond(1);
        chk("lat3_count", 32'(op_count_v[1]), 32'd1);
        accept_cmd(1, 3'b000, 8'hFF, 8'h01, 4'd2);
        wait_rsp(1, n);
        chk("lat3_add_latency", 32'(n), 32'd5);
        chk("lat3_add_result", 32'(rsp_result_v[1]), 32'h0100);
        chk("lat3_add_cout", 32'(rsp_cout_v[1]), 32'd1);
        respond(1);
        chk("lat3_count2", 32'(op_count_v[1]), 32'd2);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
